// File: rtl/mux_nw_seq.sv
// mux_nw_seq: NCH-channel, WIDTH-bit registered multiplexer with valid/ready output.
// Direct mode gives registered random access to one channel. Scan mode snapshots
// every channel and then emits one word per accepted beat, starting at channel 0.
module mux_nw_seq #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   inClk,
  input  logic                   inRst_n,
  input  logic [NCH*WIDTH-1:0]   inData,
  input  logic [SELW-1:0]        inSel,
  input  logic                   inMode,
  input  logic                   inLoad,
  input  logic                   inReady,
  output logic [WIDTH-1:0]       outData,
  output logic                   outValid,
  output logic [SELW-1:0]        outCh,
  output logic                   outLast,
  output logic                   outBusy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Index of the final channel of a scan.
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
  // With a single channel the capture word is already the last one.
  localparam logic ONE_CH = (NCH == 1);

  // Channel extraction; any index with no matching channel falls back to channel 0.
  function automatic logic [WIDTH-1:0] pick_ch(input logic [NCH*WIDTH-1:0] vec,
                                               input logic [SELW-1:0]      idx);
    logic [WIDTH-1:0] res;
    res = vec[WIDTH-1:0];
    for (int k = 1; k < NCH; k++) begin
      if (idx == SELW'(k)) res = vec[k*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  // True when idx names an existing channel.
  function automatic logic in_range(input logic [SELW-1:0] idx);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) ok = 1'b1;
    end
    return ok;
  endfunction

  state_t               r_state;
  logic [NCH*WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0]     r_data;
  logic                 r_valid;
  logic [SELW-1:0]      r_ch;
  logic                 r_last;
  logic                 r_busy;

  state_t               w_state_nx;
  logic [NCH*WIDTH-1:0] w_shadow_nx;
  logic [WIDTH-1:0]     w_data_nx;
  logic                 w_valid_nx;
  logic [SELW-1:0]      w_ch_nx;
  logic                 w_last_nx;
  logic                 w_busy_nx;

  logic                 w_accept;
  logic [SELW-1:0]      w_ch_inc;

  assign w_accept = r_valid & inReady;
  // Only consumed while r_ch < LAST_CH, so it never wraps in use.
  assign w_ch_inc = r_ch + SELW'(1);

  // Next-state and next-output decode; every register holds unless a rule below fires.
  always_comb begin
    w_state_nx  = r_state;
    w_shadow_nx = r_shadow;
    w_data_nx   = r_data;
    w_valid_nx  = r_valid;
    w_ch_nx     = r_ch;
    w_last_nx   = r_last;
    w_busy_nx   = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (!inMode) begin
          // Direct select: refresh whenever the current word is gone or being taken.
          if (inReady || !r_valid) begin
            w_data_nx  = pick_ch(inData, inSel);
            w_ch_nx    = in_range(inSel) ? inSel : '0;
            w_valid_nx = 1'b1;
            w_last_nx  = 1'b0;
          end
        end else if (!inLoad) begin
          // Scan mode armed but not started: withdraw any pending direct word.
          w_valid_nx = 1'b0;
          w_last_nx  = 1'b0;
        end else begin
          // Capture edge: snapshot all channels and present channel 0 at once.
          w_shadow_nx = inData;
          w_data_nx   = pick_ch(inData, '0);
          w_ch_nx     = '0;
          w_valid_nx  = 1'b1;
          w_last_nx   = ONE_CH;
          w_busy_nx   = 1'b1;
          w_state_nx  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_accept) begin
          if (r_last) begin
            w_state_nx = ST_IDLE;
            w_busy_nx  = 1'b0;
            w_last_nx  = 1'b0;
            w_valid_nx = 1'b0;
          end else begin
            w_ch_nx   = w_ch_inc;
            w_data_nx = pick_ch(r_shadow, w_ch_inc);
            w_last_nx = (w_ch_inc == LAST_CH);
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Output word, handshake flags and scan snapshot; reset clears them immediately.
  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nx;
      r_data   <= w_data_nx;
      r_valid  <= w_valid_nx;
      r_ch     <= w_ch_nx;
      r_last   <= w_last_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign outData  = r_data;
  assign outValid = r_valid;
  assign outCh    = r_ch;
  assign outLast  = r_last;
  assign outBusy  = r_busy;

endmodule
